// File: rtl/song_player.sv
// rtl/song_player.sv - built-in song sequencer driving note codes toward the buzzer decoder
//
// Purpose:
//   Walks a fixed note ROM for the selected song. Each ROM entry holds a note code
//   and a length in beats. Every note is one LOAD cycle, then the note code for
//   beats*BEAT_TICKS-GAP_TICKS cycles, then silence for GAP_TICKS cycles. Code 0
//   means silence. The song select is sampled every cycle. A change to the other
//   valid song restarts the sequencer on that song. An invalid select sends it to IDLE.
//
// Ports:
//   iClk         clock
//   iReset_n     asynchronous reset, active low
//   iSongs       signed song select: 1 = song 1, 2 = song 2, anything else = no song
//   oSong_Data   registered note code, 0 = silence
//   oNoteStrobe  one-cycle pulse on the first PLAY cycle of each note
//   oNoteIndex   ROM address of the current note
//   oPlaying     high in LOAD / PLAY / GAP
//   oDone        high in DONE (only reachable when LOOP = 0)

module song_player #(
    parameter int BEAT_TICKS = 12_500_000,
    parameter int GAP_TICKS  = 625_000,
    parameter bit LOOP       = 1'b1
) (
    input  logic              iClk,
    input  logic              iReset_n,
    input  logic signed [4:0] iSongs,
    output logic        [7:0] oSong_Data,
    output logic              oNoteStrobe,
    output logic        [4:0] oNoteIndex,
    output logic              oPlaying,
    output logic              oDone
);

    // The counter must hold the longest possible note (15 beats) without wrapping.
    localparam int CntW = $clog2(15 * BEAT_TICKS + 1);
    localparam logic [CntW-1:0] BeatC = CntW'(BEAT_TICKS);
    localparam logic [CntW-1:0] GapC  = CntW'(GAP_TICKS);
    localparam logic [7:0]      EndNote = 8'hFF;

    typedef enum logic [2:0] {
        sIdle,
        sLoad,
        sPlay,
        sGap,
        sDone
    } state_t;

    state_t          state, nextState;
    logic [1:0]      songId, nextSongId;
    logic [4:0]      addr, nextAddr;
    logic [7:0]      noteReg, nextNote;
    logic [CntW-1:0] cnt, nextCnt;
    logic [7:0]      nextSongData;
    logic            nextStrobe;

    logic [11:0]     romWord;
    logic [7:0]      romNote;
    logic [3:0]      romBeats;
    logic [CntW-1:0] playLen;
    logic            selValid;
    logic [1:0]      selId;

    // Note ROM: {note[7:0], beats[3:0]}. Any address past the song reads the END marker.
    function automatic logic [11:0] romEntry(input logic [1:0] song, input logic [4:0] a);
        logic [11:0] e;
        e = {EndNote, 4'd0};
        if (song == 2'd1) begin
            if (a < 5'd8) begin
                e = {3'b000, a + 5'd1, 4'd1};
            end
        end else if (song == 2'd2) begin
            case (a)
                5'd0:    e = {8'd5, 4'd1};
                5'd1:    e = {8'd5, 4'd1};
                5'd2:    e = {8'd6, 4'd2};
                5'd3:    e = {8'd5, 4'd2};
                5'd4:    e = {8'd8, 4'd2};
                5'd5:    e = {8'd7, 4'd4};
                default: e = {EndNote, 4'd0};
            endcase
        end
        return e;
    endfunction

    assign romWord  = romEntry(songId, addr);
    assign romNote  = romWord[11:4];
    assign romBeats = romWord[3:0];
    // The counter is loaded with the PLAY length minus one, so it terminates on zero.
    assign playLen  = CntW'(romBeats) * BeatC - GapC - 1'b1;

    assign selValid = (iSongs == 5'sd1) || (iSongs == 5'sd2);
    assign selId    = iSongs[1:0];

    // State register. Note code and strobe are registered from their next values.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            state       <= sIdle;
            songId      <= 2'd0;
            addr        <= 5'd0;
            noteReg     <= 8'd0;
            cnt         <= '0;
            oSong_Data  <= 8'd0;
            oNoteStrobe <= 1'b0;
        end else begin
            state       <= nextState;
            songId      <= nextSongId;
            addr        <= nextAddr;
            noteReg     <= nextNote;
            cnt         <= nextCnt;
            oSong_Data  <= nextSongData;
            oNoteStrobe <= nextStrobe;
        end
    end

    // Next-state logic
    always_comb begin
        nextState  = state;
        nextSongId = songId;
        nextAddr   = addr;
        nextNote   = noteReg;
        nextCnt    = cnt;

        case (state)
            sIdle: begin
                if (selValid) begin
                    nextState  = sLoad;
                    nextSongId = selId;
                    nextAddr   = 5'd0;
                end
            end
            sLoad: begin
                if (romNote == EndNote) begin
                    if (LOOP) begin
                        nextAddr = 5'd0;
                    end else begin
                        nextState = sDone;
                    end
                end else begin
                    nextNote  = romNote;
                    nextCnt   = playLen;
                    nextState = sPlay;
                end
            end
            sPlay: begin
                if (cnt == '0) begin
                    nextState = sGap;
                    nextCnt   = GapC - 1'b1;
                end else begin
                    nextCnt = cnt - 1'b1;
                end
            end
            sGap: begin
                if (cnt == '0) begin
                    nextState = sLoad;
                    nextAddr  = addr + 5'd1;
                end else begin
                    nextCnt = cnt - 1'b1;
                end
            end
            sDone: begin
                nextState = sDone;
            end
            default: begin
                nextState = sIdle;
            end
        endcase

        // A select change overrides every internal transition.
        if (state != sIdle) begin
            if (!selValid) begin
                nextState = sIdle;
                nextAddr  = 5'd0;
                nextCnt   = '0;
            end else if (selId != songId) begin
                nextState  = sLoad;
                nextSongId = selId;
                nextAddr   = 5'd0;
                nextCnt    = '0;
            end
        end
    end

    // Output logic. The note code and the strobe are computed from the next state so that their registers line up with it.
    always_comb begin
        nextSongData = 8'd0;
        nextStrobe   = 1'b0;
        if (nextState == sPlay) begin
            nextSongData = nextNote;
            nextStrobe   = (state != sPlay);
        end
    end

    assign oNoteIndex = addr;
    assign oPlaying   = (state == sLoad) || (state == sPlay) || (state == sGap);
    assign oDone      = (state == sDone);

endmodule

// File: tb/tb_song_player.sv
// tb/tb_song_player.sv - scoreboard bench for song_player (BEAT_TICKS=10, GAP_TICKS=2)

module tb_song_player;

    logic              iClk = 1'b0;
    logic              iReset_n;
    logic signed [4:0] iSongs;

    logic [7:0] data0, data1;
    logic       stb0, stb1;
    logic [4:0] idx0, idx1;
    logic       play0, play1;
    logic       done0, done1;

    typedef struct packed {
        logic [7:0] data;
        logic       strobe;
        logic [4:0] idx;
        logic       playing;
        logic       done;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    int s2Note[6]  = '{5, 5, 6, 5, 8, 7};
    int s2Beats[6] = '{1, 1, 2, 2, 2, 4};

    always #5 iClk = ~iClk;

    song_player #(.BEAT_TICKS(10), .GAP_TICKS(2), .LOOP(1'b0)) dut0 (
        .iClk(iClk), .iReset_n(iReset_n), .iSongs(iSongs),
        .oSong_Data(data0), .oNoteStrobe(stb0), .oNoteIndex(idx0),
        .oPlaying(play0), .oDone(done0)
    );

    song_player #(.BEAT_TICKS(10), .GAP_TICKS(2), .LOOP(1'b1)) dut1 (
        .iClk(iClk), .iReset_n(iReset_n), .iSongs(iSongs),
        .oSong_Data(data1), .oNoteStrobe(stb1), .oNoteIndex(idx1),
        .oPlaying(play1), .oDone(done1)
    );

    function automatic exp_t mk(input int d, input bit s, input int ix, input bit p, input bit dn);
        exp_t e;
        e.data    = 8'(d);
        e.strobe  = s;
        e.idx     = 5'(ix);
        e.playing = p;
        e.done    = dn;
        return e;
    endfunction

    function automatic exp_t obs(input bit which);
        if (which) return {data1, stb1, idx1, play1, done1};
        return {data0, stb0, idx0, play0, done0};
    endfunction

    function automatic string fmt(input exp_t e);
        return $sformatf("data=%0d stb=%0b idx=%0d play=%0b done=%0b",
                         e.data, e.strobe, e.idx, e.playing, e.done);
    endfunction

    function automatic int noteOf(input int song, input int i);
        return (song == 1) ? i + 1 : s2Note[i];
    endfunction

    function automatic int beatsOf(input int song, input int i);
        return (song == 1) ? 1 : s2Beats[i];
    endfunction

    // One note as seen at the outputs: LOAD, PLAY for beats*10-2 cycles, GAP for 2.
    task automatic pushNote(input int note, input int beats, input int idx);
        q.push_back(mk(0, 0, idx, 1, 0));
        for (int i = 0; i < beats * 10 - 2; i++) q.push_back(mk(note, i == 0, idx, 1, 0));
        for (int i = 0; i < 2; i++) q.push_back(mk(0, 0, idx, 1, 0));
    endtask

    task automatic pushSong(input int song, input int n);
        for (int i = 0; i < n; i++) pushNote(noteOf(song, i), beatsOf(song, i), i);
    endtask

    task automatic goIdle();
        iSongs = 5'sd0;
        repeat (2) begin @(posedge iClk); #1; end
    endtask

    task automatic test_reset();
        exp_t got;
        iReset_n = 1'b0;
        iSongs   = 5'sd0;
        #1;
        for (int w = 0; w < 2; w++) begin
            got = obs(w[0]);
            vectors++;
            if (got !== mk(0, 0, 0, 0, 0)) begin
                miscompares++;
                $display("FAIL reset dut%0d: got %s, want all zero", w, fmt(got));
            end
        end
        repeat (2) @(posedge iClk);
        #1 iReset_n = 1'b1;
        @(posedge iClk); #1;
    endtask

    task automatic test_reset_midplay();
        exp_t got, want;
        goIdle();
        iSongs = 5'sd1;
        q.push_back(mk(0, 0, 0, 1, 0));
        for (int i = 0; i < 3; i++) q.push_back(mk(1, i == 0, 0, 1, 0));
        while (q.size() > 0) begin
            @(posedge iClk); #1;
            want = q.pop_front();
            got  = obs(0);
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL midplay_run: got %s, want %s", fmt(got), fmt(want));
            end
        end
        iReset_n = 1'b0;
        #1;
        for (int w = 0; w < 2; w++) begin
            got = obs(w[0]);
            vectors++;
            if (got !== mk(0, 0, 0, 0, 0)) begin
                miscompares++;
                $display("FAIL midplay_reset dut%0d: got %s, want all zero", w, fmt(got));
            end
        end
        iSongs = 5'sd0;
        @(posedge iClk); #1;
        iReset_n = 1'b1;
        for (int i = 0; i < 3; i++) q.push_back(mk(0, 0, 0, 0, 0));
        while (q.size() > 0) begin
            @(posedge iClk); #1;
            want = q.pop_front();
            got  = obs(0);
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL midplay_release: got %s, want %s", fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_song_noloop(input int song);
        exp_t got, want;
        int   n;
        n = (song == 1) ? 8 : 6;
        goIdle();
        iSongs = 5'(song);
        pushSong(song, n);
        q.push_back(mk(0, 0, n, 1, 0));
        for (int i = 0; i < 4; i++) q.push_back(mk(0, 0, n, 0, 1));
        while (q.size() > 0) begin
            @(posedge iClk); #1;
            want = q.pop_front();
            got  = obs(0);
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL song%0d_noloop: got %s, want %s", song, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_switch();
        exp_t got, want;
        goIdle();
        iSongs = 5'sd1;
        pushSong(1, 2);
        q.push_back(mk(0, 0, 2, 1, 0));
        for (int i = 0; i < 3; i++) q.push_back(mk(3, i == 0, 2, 1, 0));
        while (q.size() > 0) begin
            @(posedge iClk); #1;
            want = q.pop_front();
            got  = obs(0);
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL switch_pre: got %s, want %s", fmt(got), fmt(want));
            end
        end
        iSongs = 5'sd2;
        q.push_back(mk(0, 0, 0, 1, 0));
        for (int i = 0; i < 4; i++) q.push_back(mk(5, i == 0, 0, 1, 0));
        while (q.size() > 0) begin
            @(posedge iClk); #1;
            want = q.pop_front();
            got  = obs(0);
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL switch_post: got %s, want %s", fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_stop();
        exp_t got, want;
        logic signed [4:0] sel[3];
        sel[0] = 5'sd0;
        sel[1] = 5'sd4;
        sel[2] = -5'sd1;
        goIdle();
        iSongs = 5'sd1;
        q.push_back(mk(0, 0, 0, 1, 0));
        for (int i = 0; i < 4; i++) q.push_back(mk(1, i == 0, 0, 1, 0));
        while (q.size() > 0) begin
            @(posedge iClk); #1;
            want = q.pop_front();
            got  = obs(0);
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL stop_pre: got %s, want %s", fmt(got), fmt(want));
            end
        end
        for (int s = 0; s < 3; s++) begin
            iSongs = sel[s];
            for (int i = 0; i < 3; i++) q.push_back(mk(0, 0, 0, 0, 0));
            while (q.size() > 0) begin
                @(posedge iClk); #1;
                want = q.pop_front();
                got  = obs(0);
                vectors++;
                if (got !== want) begin
                    miscompares++;
                    $display("FAIL stop_sel%0d: got %s, want %s", sel[s], fmt(got), fmt(want));
                end
            end
        end
    endtask

    task automatic test_loop();
        exp_t got, want;
        goIdle();
        iSongs = 5'sd1;
        pushSong(1, 8);
        q.push_back(mk(0, 0, 8, 1, 0));
        pushSong(1, 2);
        while (q.size() > 0) begin
            @(posedge iClk); #1;
            want = q.pop_front();
            got  = obs(1);
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL loop: got %s, want %s", fmt(got), fmt(want));
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_midplay();
        test_song_noloop(1);
        test_song_noloop(2);
        test_switch();
        test_stop();
        test_loop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
